steed_host_pio: RTL
===================

// Module: steed_host_pio
// PURPOSE
//  Host-side ATA/IDE PIO initiator: the opposite end of the drive register file. It turns one
//  single-beat register request into a timed ATA PIO cycle on CS/DA/DIOR-/DIOW-/DD, and
//  returns read data or write completion. Used as the host model and bridge in steed sims/SoC.
// PARAMETERS
//  T_SETUP    3    cycles CS/DA (and write DD) are stable before strobe assertion (t1)
//  T_ACTIVE   8    minimum cycles strobe is held low (t2)
//  T_RECOVER  6    cycles after strobe release before the bus returns idle (t2i)
//  T_HOLD     1    cycles DD stays driven after DIOW- rises (t4); T_HOLD <= T_RECOVER
//  IORDY_TO   255  max cycles of IORDY stretch before abort (used only with STEED_IORDY_EN)
//  CNT_W      8    timer width; every T_* value must be in 1..2**CNT_W-1
// PORTS
//  clk        in   1   core clock; all timing in clk cycles
//  rst_n      in   1   reset, asynchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when valid&&ready
//  req_write  in   1   1=register write, 0=register read
//  req_cs     in   2   chip select, one-hot active-high: 2'b01=CS0 block, 2'b10=CS1 block
//  req_da     in   3   register address
//  req_wdata  in   16  write data; 8-bit registers use [7:0]
//  rsp_valid  out  1   one-cycle completion pulse
//  rsp_rdata  out  16  read data, valid with rsp_valid (held until the next read completes)
//  rsp_err    out  1   IORDY timeout abort, valid with rsp_valid
//  io_cs      out  2   ATA CS, active-high, idle 2'b00
//  io_da      out  3   ATA DA
//  io_dior    out  1   DIOR-, active-low, idle 1
//  io_diow    out  1   DIOW-, active-low, idle 1; device latches DD on its rising edge
//  io_dd_out  out  16  DD drive value
//  io_dd_oe   out  1   DD output enable
//  io_dd_in   in  16   DD sampled value
//  io_iordy   in   1   IORDY from device
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, io_cs=00, io_da=0,
//   io_dior=1, io_diow=1, io_dd_out=0, io_dd_oe=0. All outputs are registered.
//  FSM IDLE->SETUP->ACTIVE->RECOVER->IDLE. req_ready=1 only in IDLE.
//  IDLE: on accept, latch request; drive io_cs/io_da (for a write also io_dd_out, io_dd_oe=1);
//   load the timer with T_SETUP; go to SETUP.
//  SETUP: after T_SETUP cycles, assert the strobe (DIOR- or DIOW- low); go to ACTIVE.
//  ACTIVE: the strobe is low for exactly T_ACTIVE cycles. A read samples io_dd_in into rsp_rdata
//   on the final ACTIVE edge. Then release the strobe and go to RECOVER.
//  RECOVER: io_cs/io_da stay held for T_RECOVER cycles. io_dd_oe drops T_HOLD cycles after
//   DIOW- rises. At the end, io_cs=00, rsp_valid=1 for one cycle, and the FSM returns to IDLE.
//   A new request may be accepted in that same cycle.
//  Latency: accept edge to rsp_valid = T_SETUP+T_ACTIVE+T_RECOVER+1 cycles (18 by default).
//   Back-to-back throughput is the same.
//  Only one strobe is ever asserted; io_dd_oe is never 1 during a read.
//  req_cs = 00 or 11 is still executed as given; rsp_err=0.
//  rst_n low mid-operation: strobes go high and io_dd_oe goes low immediately (async); the
//   cycle is dropped and no rsp_valid is generated.
// CONFIGURATION
//  STEED_IORDY_EN defined: in the final ACTIVE cycle, if io_iordy=0, the strobe stays low until
//   io_iordy=1, sampled through a 2-flop synchroniser. A read then samples DD on the edge
//   where the synchronised io_iordy=1. If the stretch exceeds IORDY_TO cycles: release the
//   strobe, run RECOVER normally, complete with rsp_err=1, and leave rsp_rdata unchanged.
//  STEED_IORDY_EN undefined: io_iordy is ignored, the strobe is exactly T_ACTIVE, rsp_err is
//   tied 0. The port list is identical in both builds.
// STRUCTURE
//  Package steed_pkg: FSM state enum; CS0=2'b01, CS1=2'b10; IDE_DATA=0, IDE_FEATURES/ERROR=1,
//   IDE_SEC_CNT=2, IDE_SEC_NUM=3, IDE_CYL_LO=4, IDE_CYL_HI=5, IDE_HEAD=6,
//   IDE_COMMAND/STATUS=7, IDE_DEV_CTRL=6 (on CS1).
//  Sub-module steed_pio_timer: CNT_W-bit loadable down-counter (load, value, done) shared by
//   every phase and by the IORDY timeout.
// TESTING
//  Write CS0/DA=7 data 0x00EC: io_cs=01 for 3 cycles before DIOW- falls; DIOW- low 8 cycles;
//   io_dd_oe low 1 cycle after the rise; rsp_valid 18 cycles after accept; the device model
//   sees command 0xEC.
//  Read CS0/DA=0 with the device driving 0x1234: DIOR- low 8 cycles, io_dd_oe stays 0,
//   rsp_rdata=0x1234, rsp_err=0.
//  Back-to-back write DA=2 0x05 then read DA=2: second accept in the rsp_valid cycle,
//   read returns 0x0005; DIOR-/DIOW- never low together.
//  Hold req_valid during a busy cycle: req_ready=0 until completion, exactly one accept.
//  rst_n pulse in ACTIVE of a write: DIOW-=1 and io_dd_oe=0 without a clock, no rsp_valid;
//   the next request runs normally.
//  STEED_IORDY_EN: hold io_iordy low 5 extra cycles -> strobe low 8+5+sync cycles, correct
//   data; with io_iordy stuck low -> rsp_err=1 after IORDY_TO cycles.

Source files
------------

// File: rtl/steed_pkg.sv
// Shared definitions for the steed host-side ATA PIO initiator:
// FSM state encoding, chip-select codes and the ATA register map.
package steed_pkg;

    // PIO cycle phases
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RECOVER = 2'd3
    } pio_state_t;

    // One-hot chip selects
    localparam logic [1:0] CS0 = 2'b01;   // command block
    localparam logic [1:0] CS1 = 2'b10;   // control block

    // Command-block register addresses (CS0)
    localparam logic [2:0] IDE_DATA     = 3'd0;
    localparam logic [2:0] IDE_FEATURES = 3'd1;
    localparam logic [2:0] IDE_ERROR    = 3'd1;
    localparam logic [2:0] IDE_SEC_CNT  = 3'd2;
    localparam logic [2:0] IDE_SEC_NUM  = 3'd3;
    localparam logic [2:0] IDE_CYL_LO   = 3'd4;
    localparam logic [2:0] IDE_CYL_HI   = 3'd5;
    localparam logic [2:0] IDE_HEAD     = 3'd6;
    localparam logic [2:0] IDE_COMMAND  = 3'd7;
    localparam logic [2:0] IDE_STATUS   = 3'd7;

    // Control-block register address (CS1)
    localparam logic [2:0] IDE_DEV_CTRL = 3'd6;

endpackage

// File: rtl/steed_pio_timer.sv
// Loadable down-counter shared by every PIO phase and the IORDY timeout.
// A phase loaded with N lasts N+1 cycles: done is high while value is 0.
module steed_pio_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/steed_host_pio.sv
// Host-side ATA/IDE PIO initiator. Turns one single-beat register request
// into a timed PIO cycle on CS/DA/DIOR-/DIOW-/DD and returns read data or
// write completion.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 only while the FSM is idle, and the
// request fields must be stable while req_valid is 1. rsp_valid is a single
// cycle pulse with rsp_rdata/rsp_err; there is no response back-pressure.
//
// Timing from the accept edge (edge 0):
//   edge 0            : CS/DA (and DD for writes) driven
//   edge T_SETUP      : strobe falls
//   +T_ACTIVE         : strobe rises (read data captured on this edge)
//   +T_HOLD           : DD output enable drops
//   +T_RECOVER+1      : CS released, rsp_valid pulses, back to idle
//
// Build option: define STEED_IORDY_EN to let the device stretch the strobe
// with IORDY (2-flop synchronised) with an IORDY_TO cycle abort.
module steed_host_pio
    import steed_pkg::*;
#(
    parameter int T_SETUP   = 3,
    parameter int T_ACTIVE  = 8,
    parameter int T_RECOVER = 6,
    parameter int T_HOLD    = 1,
    parameter int IORDY_TO  = 255,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_cs,
    input  logic [2:0]  req_da,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  io_cs,
    output logic [2:0]  io_da,
    output logic        io_dior,
    output logic        io_diow,
    output logic [15:0] io_dd_out,
    output logic        io_dd_oe,
    input  logic [15:0] io_dd_in,
    input  logic        io_iordy
);

    // Timer load values: a phase of N cycles loads N-1; RECOVER holds CS for
    // T_RECOVER cycles plus the completion cycle.
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(T_ACTIVE - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(T_RECOVER);
    // Timer value in RECOVER on the cycle before DD release
    localparam logic [CNT_W-1:0] HOLD_MARK  = CNT_W'(T_RECOVER - T_HOLD + 1);

    pio_state_t       state;
    pio_state_t       state_next;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;
    logic             accept;
    logic             go_active;
    logic             go_recover;
    logic             end_ok;
    logic             sample;
    logic             timeout;
    logic             finish;
    logic             wr_q;
    logic             err_q;
    logic [15:0]      rd_buf;

`ifdef STEED_IORDY_EN
    localparam logic [CNT_W-1:0] IORDY_LD = CNT_W'(IORDY_TO - 1);
    logic iordy_s1;
    logic iordy_s;
    logic stretch;
    logic stretch_set;

    // Two-flop synchroniser for the asynchronous IORDY line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iordy_s1 <= 1'b0;
            iordy_s  <= 1'b0;
        end else begin
            iordy_s1 <= io_iordy;
            iordy_s  <= iordy_s1;
        end
    end

    // Marks that the strobe is being held past T_ACTIVE waiting for IORDY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stretch <= 1'b0;
        end else if (go_recover) begin
            stretch <= 1'b0;
        end else if (stretch_set) begin
            stretch <= 1'b1;
        end
    end
`else
    localparam int unused_iordy_to = IORDY_TO;
    logic unused_iordy;
    assign unused_iordy = io_iordy;
`endif

    steed_pio_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and phase-transition strobes
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        accept     = 1'b0;
        go_active  = 1'b0;
        go_recover = 1'b0;
        end_ok     = 1'b0;
        sample     = 1'b0;
        timeout    = 1'b0;
        finish     = 1'b0;
`ifdef STEED_IORDY_EN
        stretch_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = SETUP_LD;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    go_active  = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = ACTIVE_LD;
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
`ifdef STEED_IORDY_EN
                if (stretch) begin
                    if (iordy_s) begin
                        end_ok = 1'b1;
                    end else if (tmr_done) begin
                        timeout = 1'b1;
                    end
                end else if (tmr_done) begin
                    if (iordy_s) begin
                        end_ok = 1'b1;
                    end else begin
                        stretch_set = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_val     = IORDY_LD;
                    end
                end
`else
                end_ok = tmr_done;
`endif
                if (end_ok || timeout) begin
                    go_recover = 1'b1;
                    sample     = end_ok && !wr_q;
                    tmr_load   = 1'b1;
                    tmr_val    = RECOVER_LD;
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered bus outputs, request latch and response generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            io_cs     <= 2'b00;
            io_da     <= '0;
            io_dior   <= 1'b1;
            io_diow   <= 1'b1;
            io_dd_out <= '0;
            io_dd_oe  <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_buf    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                req_ready <= 1'b0;
                io_cs     <= req_cs;
                io_da     <= req_da;
                wr_q      <= req_write;
                err_q     <= 1'b0;
                if (req_write) begin
                    io_dd_out <= req_wdata;
                    io_dd_oe  <= 1'b1;
                end
            end
            if (go_active) begin
                if (wr_q) begin
                    io_diow <= 1'b0;
                end else begin
                    io_dior <= 1'b0;
                end
            end
            if (go_recover) begin
                io_dior <= 1'b1;
                io_diow <= 1'b1;
            end
            if (sample) begin
                rd_buf <= io_dd_in;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if ((state == ST_RECOVER) && (tmr_value == HOLD_MARK)) begin
                io_dd_oe <= 1'b0;
            end
            if (finish) begin
                req_ready <= 1'b1;
                io_cs     <= 2'b00;
                io_dd_oe  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= err_q;
                if (!wr_q && !err_q) begin
                    rsp_rdata <= rd_buf;
                end
            end
        end
    end

endmodule
